hood_mode_controller: RTL and testbench

- Fan-mode sequencer for the range hood. Sits downstream of the gesture/key power controller and consumes its power_state as power_on.
- Takes single-cycle, debounced mode-key pulses and drives the motor level.
- Enforces the one-shot hurricane rule: hurricane at most once per power-on, time-limited, then auto-drops to level 2.
- Enforces a forced run-down countdown when leaving hurricane to standby.

---
 rtl/hood_mode_controller_if.sv | 23 ++
 rtl/hood_mode_controller.sv | 124 ++++++++++++
 tb/tb_hood_mode_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hood_mode_controller_if.sv
// Signal bundle between the key/power front end and the hood fan-mode sequencer.
// Keys are single-cycle pulses, power_on is a level, and all status outputs are registered.
interface hood_mode_controller_if;
  logic       power_on;
  logic       standby_key;
  logic       lvl1_key;
  logic       lvl2_key;
  logic       lvl3_key;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] seconds_left;
  logic       hurricane_used;

  modport master (
    output power_on, standby_key, lvl1_key, lvl2_key, lvl3_key,
    input  mode, fan_level, seconds_left, hurricane_used
  );

  modport slave (
    input  power_on, standby_key, lvl1_key, lvl2_key, lvl3_key,
    output mode, fan_level, seconds_left, hurricane_used
  );
endinterface

// File: rtl/hood_mode_controller.sv
// Range-hood fan-mode sequencer: level selection, a one-shot timed hurricane mode,
// and a forced run-down countdown when standby is requested from hurricane.
module hood_mode_controller #(
  parameter int TICK_CYCLES    = 100000000,
  parameter int HURRICANE_SECS = 60,
  parameter int RETURN_SECS    = 60
) (
  input logic                  clk,
  input logic                  reset,
  hood_mode_controller_if.slave bus
);
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_CYCLES - 1);
  localparam logic [7:0] HUR_SECS = 8'(HURRICANE_SECS);
  localparam logic [7:0] RET_SECS = 8'(RETURN_SECS);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_STANDBY = 3'd1;
  localparam logic [2:0] ST_LEVEL1  = 3'd2;
  localparam logic [2:0] ST_LEVEL2  = 3'd3;
  localparam logic [2:0] ST_HURR    = 3'd4;
  localparam logic [2:0] ST_RETURN  = 3'd5;

  logic [2:0]       mode_q, mode_d;
  logic [7:0]       secs_q, secs_d;
  logic             used_q, used_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             counting;
  logic             tick;

  assign counting = (mode_q == ST_HURR) || (mode_q == ST_RETURN);
  assign tick     = counting && (cnt_q == TICK_MAX);

  always_comb begin
    mode_d = mode_q;
    secs_d = secs_q;
    used_d = used_q;
    cnt_d  = '0;
    if (counting) cnt_d = tick ? '0 : cnt_q + 1'b1;

    if (!bus.power_on) begin
      mode_d = ST_OFF;
      secs_d = '0;
      used_d = 1'b0;
      cnt_d  = '0;
    end else begin
      case (mode_q)
        ST_OFF: mode_d = ST_STANDBY;
        // A pressed higher-priority key wins even when its own action is a no-op.
        ST_STANDBY: begin
          if (bus.standby_key) begin
            mode_d = ST_STANDBY;
          end else if (bus.lvl3_key) begin
            if (!used_q) begin
              mode_d = ST_HURR;
              secs_d = HUR_SECS;
              used_d = 1'b1;
              cnt_d  = '0;
            end
          end else if (bus.lvl2_key) begin
            mode_d = ST_LEVEL2;
          end else if (bus.lvl1_key) begin
            mode_d = ST_LEVEL1;
          end
        end
        ST_LEVEL1, ST_LEVEL2: begin
          if (bus.standby_key)   mode_d = ST_STANDBY;
          else if (bus.lvl3_key) mode_d = mode_q;
          else if (bus.lvl2_key) mode_d = ST_LEVEL2;
          else if (bus.lvl1_key) mode_d = ST_LEVEL1;
        end
        ST_HURR: begin
          if (bus.standby_key) begin
            mode_d = ST_RETURN;
            secs_d = RET_SECS;
            cnt_d  = '0;
          end else if (tick) begin
            secs_d = secs_q - 8'd1;
            if (secs_q == 8'd1) mode_d = ST_LEVEL2;
          end
        end
        ST_RETURN: begin
          if (tick) begin
            secs_d = secs_q - 8'd1;
            if (secs_q == 8'd1) mode_d = ST_STANDBY;
          end
        end
        default: begin
          mode_d = ST_OFF;
          secs_d = '0;
          used_d = 1'b0;
          cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= ST_OFF;
      secs_q <= '0;
      used_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      secs_q <= secs_d;
      used_q <= used_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    case (mode_q)
      ST_LEVEL1:           bus.fan_level = 2'd1;
      ST_LEVEL2:           bus.fan_level = 2'd2;
      ST_HURR, ST_RETURN:  bus.fan_level = 2'd3;
      default:             bus.fan_level = 2'd0;
    endcase
  end

  assign bus.mode           = mode_q;
  assign bus.seconds_left   = secs_q;
  assign bus.hurricane_used = used_q;
endmodule

// File: tb/tb_hood_mode_controller.sv
// Bench for hood_mode_controller: directed scenarios plus random key traffic,
// compared against a timeline model (elapsed cycles since entering a timed mode).
module tb_hood_mode_controller;
  localparam int TICK = 4;
  localparam int HSEC = 3;
  localparam int RSEC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  hood_mode_controller_if bus();

  hood_mode_controller #(
    .TICK_CYCLES(TICK), .HURRICANE_SECS(HSEC), .RETURN_SECS(RSEC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model: mode number, sticky flag, and the active countdown as start value + elapsed cycles
  int m_mode = 0;
  int m_used = 0;
  int m_start = 0;
  int m_elapsed = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_fan();
    case (m_mode)
      2: return 1;
      3: return 2;
      4, 5: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int m_secs();
    if (m_mode == 4 || m_mode == 5) return m_start - m_elapsed / TICK;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_used = 0; m_start = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input logic p, input logic s, input logic k1,
                            input logic k2, input logic k3);
    int win;
    win = s ? 9 : k3 ? 3 : k2 ? 2 : k1 ? 1 : 0;
    if (!p) begin
      m_mode = 0; m_used = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 5) begin
      m_elapsed++;
      if (m_elapsed == RSEC * TICK) m_mode = 1;
    end else if (m_mode == 4) begin
      if (s) begin
        m_mode = 5; m_start = RSEC; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == HSEC * TICK) m_mode = 3;
      end
    end else if (m_mode == 1) begin
      if (win == 3 && m_used == 0) begin
        m_mode = 4; m_used = 1; m_start = HSEC; m_elapsed = 0;
      end else if (win == 2) m_mode = 3;
      else if (win == 1) m_mode = 2;
    end else begin
      if (win == 9) m_mode = 1;
      else if (win == 2) m_mode = 3;
      else if (win == 1) m_mode = 2;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".mode"}, int'(bus.mode), m_mode);
    check_val({tag, ".fan"},  int'(bus.fan_level), m_fan());
    check_val({tag, ".secs"}, int'(bus.seconds_left), m_secs());
    check_val({tag, ".used"}, int'(bus.hurricane_used), m_used);
  endtask

  // called #1 after a rising edge; drives inputs for the next edge then checks
  task automatic cyc(input string tag, input logic p, input logic s, input logic k1,
                     input logic k2, input logic k3);
    bus.power_on = p; bus.standby_key = s;
    bus.lvl1_key = k1; bus.lvl2_key = k2; bus.lvl3_key = k3;
    @(posedge clk);
    model_step(p, s, k1, k2, k3);
    #1;
    bus.standby_key = 1'b0; bus.lvl1_key = 1'b0;
    bus.lvl2_key = 1'b0; bus.lvl3_key = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.power_on = 1'b0; bus.standby_key = 1'b0;
    bus.lvl1_key = 1'b0; bus.lvl2_key = 1'b0; bus.lvl3_key = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // level selection
    cyc("pwr_on", 1, 0, 0, 0, 0);
    check_val("pwr_on.const", int'(bus.mode), 1);
    cyc("lvl2", 1, 0, 0, 1, 0);
    check_val("lvl2.const_fan", int'(bus.fan_level), 2);
    cyc("lvl2_again", 1, 0, 0, 1, 0);
    cyc("lvl1", 1, 0, 1, 0, 0);
    cyc("lvl3_in_lvl1", 1, 0, 0, 0, 1);
    cyc("stby", 1, 1, 0, 0, 0);

    // hurricane runs out and drops to level 2
    cyc("hur", 1, 0, 0, 0, 1);
    check_val("hur.const_secs", int'(bus.seconds_left), 3);
    idle("hur_run", 12);
    check_val("hur_end.const_mode", int'(bus.mode), 3);

    // one-shot rule, then re-armed by a power cycle
    cyc("stby2", 1, 1, 0, 0, 0);
    cyc("hur_denied", 1, 0, 0, 0, 1);
    cyc("pwr_off", 0, 0, 0, 0, 0);
    cyc("pwr_on2", 1, 0, 0, 0, 1);
    cyc("hur_again", 1, 0, 0, 0, 1);
    check_val("hur_again.const_secs", int'(bus.seconds_left), 3);

    // standby from hurricane at seconds_left=2 enters run-down, keys ignored
    idle("hur_wait", 4);
    cyc("rdown", 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc("rdown_keys", 1, 0, (i % 2) == 0, 0, (i % 3) == 0);
    check_val("rdown.const_mode", int'(bus.mode), 1);

    // same-cycle key priority
    cyc("pri_l1", 1, 0, 1, 0, 0);
    cyc("pri_s_l2", 1, 1, 0, 1, 0);
    cyc("pwr_off2", 0, 0, 0, 0, 0);
    cyc("pwr_on3", 1, 0, 0, 0, 0);
    cyc("pri_l3_l1", 1, 0, 1, 0, 1);
    check_val("pri_l3_l1.const", int'(bus.mode), 4);

    // power loss during run-down
    cyc("rd2", 1, 1, 0, 0, 0);
    idle("rd2_wait", 3);
    cyc("rd2_off", 0, 0, 0, 0, 0);
    cyc("rd2_on", 1, 0, 0, 0, 0);

    // async reset mid-hurricane
    cyc("ar_hur", 1, 0, 0, 0, 1);
    idle("ar_run", 5);
    reset = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("ar_on", 1, 0, 0, 0, 0);
    cyc("ar_hur2", 1, 0, 0, 0, 1);
    idle("ar_full", 4);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc("rand", $urandom_range(0, 60) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end
endmodule
